core_oamdma: RTL
================

CORE_OAMDMA -- requirements
Module: core_oamdma

Interface
REQ-001 Parameter P_trig_addr, default 16'h4014, CPU write address that starts a transfer.
REQ-002 Parameter P_dest_addr, default 16'h2004, fixed destination address of every DMA write.
REQ-003 I_clock  in  1  single system clock; all state on its rising edge.
REQ-004 I_reset  in  1  asynchronous, active-high reset.
REQ-005 I_mcyc  in  1  one-I_clock strobe marking the end of a bus (M-) cycle; all state advances only when it is high.
REQ-006 I_cpu_addr  in  16  core address for the current M-cycle.
REQ-007 I_cpu_wr_data  in  8  core write data.
REQ-008 I_cpu_rdwr  in  1  core direction: 1 = read, 0 = write.
REQ-009 I_rd_data  in  8  bus read data, valid when I_mcyc is high.
REQ-010 O_addr  out  16  arbitrated bus address.
REQ-011 O_wr_data  out  8  arbitrated bus write data.
REQ-012 O_rdwr  out  1  arbitrated bus direction: 1 = read, 0 = write.
REQ-013 O_cpu_ready  out  1  core ready/halt: 0 stalls the core.
REQ-014 O_busy  out  1  high whenever a transfer is pending or active.

Function
REQ-015 The block SHALL hold five states: IDLE, HALT, ALIGN, READ, WRITE; state changes only on I_clock edges where I_mcyc = 1.
REQ-016 A parity bit SHALL toggle on every I_mcyc strobe; parity 0 = get cycle, parity 1 = put cycle.
REQ-017 IDLE: when I_mcyc = 1, I_cpu_rdwr = 0 and I_cpu_addr = P_trig_addr, latch page <= I_cpu_wr_data, index <= 0, go to HALT.
REQ-018 HALT: when I_mcyc = 1 and I_cpu_rdwr = 0 (core still writing; RDY is ignored on writes), remain in HALT.
REQ-019 HALT: when I_mcyc = 1 and I_cpu_rdwr = 1, go to READ if the next cycle is a get (current parity = 1), else to ALIGN.
REQ-020 ALIGN: one dummy cycle; on I_mcyc go to READ.
REQ-021 READ: drive O_addr = {page, index}, O_rdwr = 1; on I_mcyc latch data <= I_rd_data and go to WRITE.
REQ-022 WRITE: drive O_addr = P_dest_addr, O_wr_data = data, O_rdwr = 0; on I_mcyc increment index.
REQ-023 WRITE exit: if index was 8'hFF, go to IDLE; otherwise go to READ.
REQ-024 Index SHALL be 8 bits and wrap 8'hFF to 8'h00; the source address never crosses the 256-byte page.
REQ-025 In IDLE, HALT and ALIGN, the outputs SHALL pass through: O_addr = I_cpu_addr, O_wr_data = I_cpu_wr_data, O_rdwr = I_cpu_rdwr.
REQ-026 In READ and WRITE, the block SHALL own the bus outputs.
REQ-027 O_cpu_ready SHALL be 1 only in IDLE; O_busy = ~O_cpu_ready; both are decoded from the registered state, with no combinational path from inputs.
REQ-028 Transfer length SHALL be 513 M-cycles (HALT exits directly to READ) or 514 M-cycles (via ALIGN), measured from the first HALT cycle to the return to IDLE, with exactly 256 reads and 256 writes.
REQ-029 A trigger-address write seen while not in IDLE SHALL be ignored; page is unchanged.
REQ-030 Writes to addresses other than P_trig_addr and all reads SHALL never start a transfer.
REQ-031 With I_mcyc held low, all state, parity, index and data SHALL hold indefinitely.

Reset
REQ-032 On asserting I_reset, the block SHALL immediately (asynchronously) set state = IDLE, parity = 0, page = 8'h00, index = 8'h00, data = 8'h00.
REQ-033 In reset, O_cpu_ready = 1, O_busy = 0 and bus outputs are pass-through.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no further DMA bus cycles.
REQ-035 On deassertion, the first I_mcyc strobe SHALL be treated as parity 0.

Verification
REQ-036 Core writes 8'h02 to 16'h4014 on a parity-0 cycle, then reads -> HALT goes directly to READ; reads 16'h0200..16'h02FF; each byte is written to 16'h2004; O_cpu_ready is low for 513 M-cycles.
REQ-037 Same trigger on a parity-1 cycle -> one ALIGN cycle inserted; O_cpu_ready is low for 514 M-cycles; the first DMA read is on a get cycle.
REQ-038 After the trigger, the core performs two more writes (push sequence) -> the block stays in HALT for those cycles with pass-through bus; READ starts only after the first core read cycle.
REQ-039 Source memory holds pattern data = addr[7:0] ^ 8'h5A on page 8'h07 -> the 256 writes to 16'h2004 carry exactly that sequence; index wraps to 8'h00 and the final state is IDLE.
REQ-040 Reset pulse while in WRITE with index 8'h40 -> immediately IDLE; O_cpu_ready = 1; no further accesses to 16'h2004; a new 16'h4014 write after reset starts again at index 8'h00.
REQ-041 A write to 16'h4015 and a read of 16'h4014 -> no state change, and O_busy stays 0.

Source files
------------

// File: rtl/core_oamdma.sv
// rtl/core_oamdma.sv - OAM DMA controller: halts the core and copies one 256-byte page to a fixed port
//
// Purpose:
//   A core write of the page number to P_trig_addr halts the core and starts a
//   256-byte copy from {page, 8'h00}..{page, 8'hFF} to P_dest_addr, one read
//   and one write per byte, aligned so that every DMA read falls on a get cycle.
//
// Ports:
//   I_clock        in   system clock, rising edge
//   I_reset        in   asynchronous active-high reset
//   I_mcyc         in   end-of-M-cycle strobe; all state advances only when high
//   I_cpu_addr     in   [15:0] core address
//   I_cpu_wr_data  in   [7:0]  core write data
//   I_cpu_rdwr     in   core direction (1 = read, 0 = write)
//   I_rd_data      in   [7:0]  bus read data, valid with I_mcyc
//   O_addr         out  [15:0] arbitrated bus address
//   O_wr_data      out  [7:0]  arbitrated bus write data
//   O_rdwr         out  arbitrated bus direction (1 = read, 0 = write)
//   O_cpu_ready    out  0 stalls the core
//   O_busy         out  high while a transfer is pending or active

module core_oamdma #(
  parameter logic [15:0] P_trig_addr = 16'h4014,
  parameter logic [15:0] P_dest_addr = 16'h2004
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_mcyc,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_cpu_ready,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        parity_q, parity_d;   // 0 = get cycle, 1 = put cycle
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= ST_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    page_d   = page_q;
    index_d  = index_q;
    data_d   = data_q;
    if (I_mcyc) begin
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          if (!I_cpu_rdwr && (I_cpu_addr == P_trig_addr)) begin
            page_d  = I_cpu_wr_data;
            index_d = 8'h00;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          // The core only honours the halt on a read cycle; writes run through.
          // Current parity 1 means the following cycle is a get, so the read
          // can start immediately; otherwise burn one cycle in ALIGN.
          if (I_cpu_rdwr) begin
            state_d = parity_q ? ST_READ : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          state_d = ST_READ;
        end
        ST_READ: begin
          data_d  = I_rd_data;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          index_d = index_q + 8'h01;
          state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Bus ownership depends only on registered state; pass-through otherwise.
  always_comb begin
    O_addr    = I_cpu_addr;
    O_wr_data = I_cpu_wr_data;
    O_rdwr    = I_cpu_rdwr;
    case (state_q)
      ST_READ: begin
        O_addr    = {page_q, index_q};
        O_wr_data = data_q;
        O_rdwr    = 1'b1;
      end
      ST_WRITE: begin
        O_addr    = P_dest_addr;
        O_wr_data = data_q;
        O_rdwr    = 1'b0;
      end
      default: begin
        O_addr    = I_cpu_addr;
        O_wr_data = I_cpu_wr_data;
        O_rdwr    = I_cpu_rdwr;
      end
    endcase
  end

  assign O_cpu_ready = (state_q == ST_IDLE);
  assign O_busy      = ~O_cpu_ready;

endmodule
